// File: rtl/alarm_log_master.sv
`default_nettype none
// ============================================================================
// Module      : alarm_log_master
// Description : Avalon-MM master that keeps a circular log of timestamped
//               alarm events in on-chip RAM. Each entry is one 32-bit word,
//               {timestamp, code}. Log entries can be read back by index,
//               where index 0 is the oldest entry. A clear request zeroes
//               the whole log region.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_log_master #(
    parameter int                ADDR_W       = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 11'h600,
    parameter int                LOG_DEPTH    = 256,
    parameter int                TS_W         = 24,
    parameter int                READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         event_valid,
    input  logic [7:0]                   event_code,
    output logic                         event_ready,
    input  logic                         clear_req,
    output logic                         clear_busy,
    input  logic                         rd_req,
    input  logic [$clog2(LOG_DEPTH)-1:0] rd_index,
    output logic                         rd_ready,
    output logic                         rd_valid,
    output logic [31:0]                  rd_data,
    output logic                         rd_err,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    output logic [ADDR_W-1:0]            avm_address,
    output logic [3:0]                   avm_byteenable,
    output logic                         avm_write,
    output logic [31:0]                  avm_writedata,
    output logic                         avm_read,
    input  logic [31:0]                  avm_readdata,
    input  logic                         avm_waitrequest
);

    localparam int IDX_W = $clog2(LOG_DEPTH);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_write    = 3'd1;
    localparam logic [2:0] c_st_rd_issue = 3'd2;
    localparam logic [2:0] c_st_rd_wait  = 3'd3;
    localparam logic [2:0] c_st_rd_done  = 3'd4;
    localparam logic [2:0] c_st_clear    = 3'd5;

    localparam logic [IDX_W:0]   c_count_full = (IDX_W+1)'(LOG_DEPTH);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(LOG_DEPTH - 1);
    localparam logic [LAT_W-1:0] c_lat_last   = LAT_W'(READ_LATENCY - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [TS_W-1:0]   r_ts;
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [IDX_W:0]    r_count;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rd_data;
    logic              r_rd_err;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [IDX_W-1:0]  r_clr_idx;

    logic              w_idle;
    logic              w_rd_oob;
    logic [IDX_W-1:0]  w_rd_slot;
    logic [ADDR_W-1:0] w_rd_addr;

    // Oldest entry sits at wr_ptr - count; the slot arithmetic wraps inside
    // the log region because it is carried out in IDX_W bits.
    assign w_idle    = (r_state == c_st_idle);
    assign w_rd_oob  = ({1'b0, rd_index} >= r_count);
    assign w_rd_slot = r_wr_ptr - r_count[IDX_W-1:0] + rd_index;
    assign w_rd_addr = BASE_ADDR + ADDR_W'(w_rd_slot);

    assign event_ready    = w_idle & ~clear_req;
    assign rd_ready       = w_idle & ~clear_req & ~event_valid;
    assign clear_busy     = (r_state == c_st_clear);
    assign rd_valid       = (r_state == c_st_rd_done);
    assign rd_data        = r_rd_data;
    assign rd_err         = r_rd_err;
    assign log_count      = r_count;
    assign log_overflow   = r_overflow;
    assign avm_address    = r_addr;
    assign avm_byteenable = 4'hF;
    assign avm_write      = (r_state == c_st_write) || (r_state == c_st_clear);
    assign avm_writedata  = r_wdata;
    assign avm_read       = (r_state == c_st_rd_issue);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; IDLE arbitrates clear > event > read.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (clear_req) begin
                    w_state_nxt = c_st_clear;
                end else if (event_valid) begin
                    w_state_nxt = c_st_write;
                end else if (rd_req) begin
                    w_state_nxt = w_rd_oob ? c_st_rd_done : c_st_rd_issue;
                end
            end
            c_st_write: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_rd_issue: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = c_st_rd_wait;
                end
            end
            c_st_rd_wait: begin
                if (r_lat_cnt == c_lat_last) begin
                    w_state_nxt = c_st_rd_done;
                end
            end
            c_st_rd_done: begin
                w_state_nxt = c_st_idle;
            end
            c_st_clear: begin
                if (!avm_waitrequest && (r_clr_idx == c_idx_last)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Datapath: timestamp, pointers, bus address/data and read response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
            r_lat_cnt  <= '0;
            r_clr_idx  <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            case (r_state)
                c_st_idle: begin
                    if (clear_req) begin
                        r_addr    <= BASE_ADDR;
                        r_wdata   <= '0;
                        r_clr_idx <= '0;
                    end else if (event_valid) begin
                        r_addr  <= BASE_ADDR + ADDR_W'(r_wr_ptr);
                        r_wdata <= {r_ts, event_code};
                    end else if (rd_req) begin
                        if (w_rd_oob) begin
                            r_rd_data <= '0;
                            r_rd_err  <= 1'b1;
                        end else begin
                            r_addr    <= w_rd_addr;
                            r_lat_cnt <= '0;
                        end
                    end
                end
                c_st_write: begin
                    if (!avm_waitrequest) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_count == c_count_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                c_st_rd_wait: begin
                    if (r_lat_cnt == c_lat_last) begin
                        r_rd_data <= avm_readdata;
                        r_rd_err  <= 1'b0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                c_st_clear: begin
                    if (!avm_waitrequest) begin
                        if (r_clr_idx == c_idx_last) begin
                            r_wr_ptr   <= '0;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                        end else begin
                            r_clr_idx <= r_clr_idx + 1'b1;
                            r_addr    <= r_addr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_log_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_log_master
// Description : Self-checking bench for alarm_log_master with a simple
//               Avalon-MM RAM model (read latency 1, controllable waitrequest).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_log_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        event_valid;
    logic [7:0]  event_code;
    logic        event_ready;
    logic        clear_req;
    logic        clear_busy;
    logic        rd_req;
    logic [7:0]  rd_index;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [8:0]  log_count;
    logic        log_overflow;
    logic [10:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    always #5 clk = ~clk;

    alarm_log_master dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .event_valid     (event_valid),
        .event_code      (event_code),
        .event_ready     (event_ready),
        .clear_req       (clear_req),
        .clear_busy      (clear_busy),
        .rd_req          (rd_req),
        .rd_index        (rd_index),
        .rd_ready        (rd_ready),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_err          (rd_err),
        .log_count       (log_count),
        .log_overflow    (log_overflow),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_byteenable),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    // RAM slave model: accepts on waitrequest=0, read data one cycle later.
    logic [31:0] mem [0:2047];
    int   n_wr = 0;
    int   n_rd = 0;
    logic both_seen = 1'b0;
    int   tb_cyc = 0;

    always @(posedge clk) begin
        if (avm_write && !avm_waitrequest) begin
            mem[avm_address] <= avm_writedata;
            n_wr <= n_wr + 1;
        end
        if (avm_read && !avm_waitrequest) begin
            avm_readdata <= mem[avm_address];
            n_rd <= n_rd + 1;
        end
        if (avm_write && avm_read) both_seen <= 1'b1;
    end

    // Reference timestamp: cycles since the last reset edge.
    always @(posedge clk) begin
        if (!reset_n) tb_cyc <= 0;
        else          tb_cyc <= tb_cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    // All tasks are entered and left in the low half of the clock.
    task automatic wait_idle();
        int k = 0;
        #1;
        while (!event_ready && k < 1000) begin
            @(negedge clk); #1; k++;
        end
        if (!event_ready) timeout("wait_idle");
    endtask

    task automatic send_event(input logic [7:0] code, output logic [31:0] word);
        int k = 0;
        event_valid = 1'b1;
        event_code  = code;
        #1;
        while (!event_ready && k < 1000) begin
            @(negedge clk); #1; k++;
        end
        if (!event_ready) timeout("event_accept");
        word = {tb_cyc[23:0], code};
        @(negedge clk);
        event_valid = 1'b0;
        wait_idle();
    endtask

    task automatic read_entry(input logic [7:0] idx, output logic [31:0] data, output logic err);
        int k = 0;
        rd_req   = 1'b1;
        rd_index = idx;
        #1;
        while (!rd_ready && k < 1000) begin
            @(negedge clk); #1; k++;
        end
        if (!rd_ready) timeout("rd_accept");
        @(negedge clk);
        rd_req = 1'b0;
        k = 0;
        #1;
        while (!rd_valid && k < 100) begin
            @(negedge clk); #1; k++;
        end
        if (!rd_valid) timeout("rd_valid");
        data = rd_data;
        err  = rd_err;
        @(negedge clk);
        wait_idle();
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic        err;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t     tbl [6];
    logic [31:0] w1 [3];
    logic [31:0] ev [1:258];
    logic [31:0] ws, got;
    logic        gerr, seen;
    int          nw0, nr0, zeros, k;

    initial begin
        reset_n = 1'b0; event_valid = 1'b0; event_code = 8'h00; clear_req = 1'b0;
        rd_req = 1'b0; rd_index = 8'h00; avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        #1;
        check("rst_avm_write", avm_write, 0);
        check("rst_avm_read", avm_read, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_log_count", log_count, 0);
        check("rst_overflow", log_overflow, 0);
        check("rst_event_ready", event_ready, 1);
        check("byteenable", avm_byteenable, 4'hF);

        // Three events, no stalls
        send_event(8'h11, w1[0]);
        send_event(8'h22, w1[1]);
        send_event(8'h33, w1[2]);
        check("t1_word0", mem[11'h600], w1[0]);
        check("t1_word1", mem[11'h601], w1[1]);
        check("t1_word2", mem[11'h602], w1[2]);
        check("t1_ts_order", (w1[1][31:8] > w1[0][31:8]) && (w1[2][31:8] > w1[1][31:8]), 1);
        check("t1_count", log_count, 3);

        // Readback table, including out-of-range indices
        tbl[0] = '{8'd0,   1'b0, w1[0]};
        tbl[1] = '{8'd1,   1'b0, w1[1]};
        tbl[2] = '{8'd2,   1'b0, w1[2]};
        tbl[3] = '{8'd3,   1'b1, 32'h0};
        tbl[4] = '{8'd5,   1'b1, 32'h0};
        tbl[5] = '{8'd255, 1'b1, 32'h0};
        for (int i = 0; i < 6; i++) begin
            nr0 = n_rd;
            read_entry(tbl[i].idx, got, gerr);
            check($sformatf("tbl%0d_data", i), got, tbl[i].data);
            check($sformatf("tbl%0d_err", i), gerr, tbl[i].err);
            check($sformatf("tbl%0d_busreads", i), n_rd - nr0, tbl[i].err ? 0 : 1);
        end
        read_entry(8'd1, got, gerr);
        repeat (3) @(negedge clk);
        #1;
        check("rd_data_hold", rd_data, w1[1]);

        // Write stalled by waitrequest for several cycles
        avm_waitrequest = 1'b1;
        event_valid = 1'b1;
        event_code  = 8'h44;
        #1;
        check("t2_ready_before", event_ready, 1);
        ws  = {tb_cyc[23:0], 8'h44};
        nw0 = n_wr;
        @(negedge clk);
        event_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("t2_write_c%0d", c), avm_write, 1);
            check($sformatf("t2_addr_c%0d", c), avm_address, 11'h603);
            check($sformatf("t2_data_c%0d", c), avm_writedata, ws);
            check($sformatf("t2_ready_c%0d", c), event_ready, 0);
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        wait_idle();
        check("t2_one_write", n_wr - nw0, 1);
        check("t2_word", mem[11'h603], ws);
        check("t2_count", log_count, 4);

        // Overflow: LOG_DEPTH+2 events after reset
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 258; e++) begin
            send_event(8'(e), ev[e]);
        end
        check("t3_overflow", log_overflow, 1);
        check("t3_count", log_count, 256);
        check("t3_word600", mem[11'h600], ev[257]);
        check("t3_word601", mem[11'h601], ev[258]);
        check("t3_word602", mem[11'h602], ev[3]);
        read_entry(8'd0, got, gerr);
        check("t3_oldest", got, ev[3]);
        check("t3_oldest_err", gerr, 0);
        read_entry(8'd255, got, gerr);
        check("t3_newest", got, ev[258]);
        read_entry(8'd1, got, gerr);
        check("t3_idx1", got, ev[4]);

        // Clear, event and read requested together
        clear_req = 1'b1; event_valid = 1'b1; event_code = 8'h55; rd_req = 1'b1; rd_index = 8'd0;
        #1;
        check("t5_event_ready", event_ready, 0);
        check("t5_rd_ready", rd_ready, 0);
        nw0 = n_wr;
        @(negedge clk);
        clear_req = 1'b0;
        #1;
        check("t5_busy", clear_busy, 1);
        k = 0;
        while (clear_busy && k < 2000) begin
            @(negedge clk);
            avm_waitrequest = ($urandom_range(0, 3) == 0);
            #1; k++;
        end
        if (clear_busy) timeout("clear_done");
        avm_waitrequest = 1'b0;
        zeros = 0;
        for (int a = 0; a < 256; a++) if (mem[11'h600 + a] == 32'h0) zeros++;
        check("t5_clear_writes", n_wr - nw0, 256);
        check("t5_zero_words", zeros, 256);
        check("t5_count", log_count, 0);
        check("t5_overflow", log_overflow, 0);
        check("t5_event_ready_after", event_ready, 1);
        check("t5_rd_ready_after", rd_ready, 0);
        ws = {tb_cyc[23:0], 8'h55};
        @(negedge clk);
        event_valid = 1'b0;
        k = 0;
        #1;
        while (!rd_ready && k < 100) begin
            @(negedge clk); #1; k++;
        end
        if (!rd_ready) timeout("t5_rd_accept");
        check("t5_event_before_read", n_wr - nw0, 257);
        @(negedge clk);
        rd_req = 1'b0;
        k = 0;
        #1;
        while (!rd_valid && k < 100) begin
            @(negedge clk); #1; k++;
        end
        if (!rd_valid) timeout("t5_rd_valid");
        check("t5_rd_data", rd_data, ws);
        check("t5_rd_err", rd_err, 0);
        @(negedge clk);
        wait_idle();

        // Reset during a stalled read issue
        avm_waitrequest = 1'b1;
        rd_req = 1'b1; rd_index = 8'd0;
        nr0 = n_rd;
        #1;
        check("t6_rd_ready", rd_ready, 1);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        check("t6_read_high", avm_read, 1);
        check("t6_read_addr", avm_address, 11'h600);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("t6_read_low", avm_read, 0);
        check("t6_count", log_count, 0);
        check("t6_rd_valid", rd_valid, 0);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (rd_valid) seen = 1'b1;
        end
        check("t6_no_rd_valid", seen, 0);
        check("t6_no_bus_read", n_rd - nr0, 0);
        check("never_rw_together", both_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
